// File: rtl/multi_port_mem_control_if.sv
// Requester-side bus of multi_port_mem_control: per-channel requests in,
// per-channel completion pulses and shared read data out.
interface multi_port_mem_control_if #(
    parameter int NCH       = 2,
    parameter int DWIDTH    = 32,
    parameter int IN_AWIDTH = 16
);
    logic [NCH-1:0]           req_valid;
    logic [NCH-1:0]           req_rw;
    logic [NCH*IN_AWIDTH-1:0] req_addr;
    logic [NCH*DWIDTH-1:0]    req_wdata;
    logic [NCH-1:0]           rsp_valid;
    logic [NCH-1:0]           rsp_err;
    logic [DWIDTH-1:0]        rsp_rdata;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/multi_port_mem_control.sv
// Round-robin arbiter of NCH requesters onto one synchronous RAM port.
// Define MEMCTRL_RANGE_CHECK_EN to reject requests with nonzero upper address bits.
module multi_port_mem_control #(
    parameter int NCH       = 2,
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 8,
    parameter int IN_AWIDTH = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multi_port_mem_control_if.slave bus,
    output logic                  mem_rdEn,
    output logic                  mem_wrEn,
    output logic [AWIDTH-1:0]     mem_addr,
    output logic [DWIDTH-1:0]     mem_wdata,
    input  logic [DWIDTH-1:0]     mem_rdata
);
    // state | meaning
    // IDLE  | scan requesters from rr_ptr, grant and latch the winner
    // ISSUE | one-cycle RAM strobe (read or write)
    // WAIT  | count down the RAM read latency, capture data on terminal count
    // RESP  | rsp_valid pulse to the granted channel, advance rr_ptr
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     lat_next;
    logic [NCH-1:0]    lat_onehot;
    logic              lat_rw;
    logic [2:0]        wait_cnt;

    logic              gnt_found;
    logic [NCH-1:0]    gnt_onehot;
    logic [PW-1:0]     gnt_next;
    logic              gnt_rw;
    logic              gnt_oor;
    logic [AWIDTH-1:0] gnt_addr;
    logic [DWIDTH-1:0] gnt_wdata;
    logic [PW:0]       scan;

    always_comb begin
        gnt_found  = 1'b0;
        gnt_onehot = '0;
        gnt_next   = '0;
        gnt_rw     = 1'b0;
        gnt_oor    = 1'b0;
        gnt_addr   = '0;
        gnt_wdata  = '0;
        scan       = '0;
        for (int i = 0; i < NCH; i++) begin
            scan = {1'b0, rr_ptr} + (PW+1)'(i);
            if (scan >= (PW+1)'(NCH))
                scan = scan - (PW+1)'(NCH);
            for (int k = 0; k < NCH; k++) begin
                if (!gnt_found && scan == (PW+1)'(k) && bus.req_valid[k]) begin
                    gnt_found     = 1'b1;
                    gnt_onehot[k] = 1'b1;
                    gnt_next      = (k == NCH-1) ? '0 : PW'(k+1);
                    gnt_rw        = bus.req_rw[k];
                    gnt_addr      = bus.req_addr[k*IN_AWIDTH +: AWIDTH];
                    gnt_wdata     = bus.req_wdata[k*DWIDTH +: DWIDTH];
`ifdef MEMCTRL_RANGE_CHECK_EN
                    gnt_oor       = (bus.req_addr[k*IN_AWIDTH +: IN_AWIDTH] >> AWIDTH) != '0;
`else
                    gnt_oor       = 1'b0;
`endif
                end
            end
        end
    end

    // mem_addr/mem_wdata are loaded at grant and double as the latched request fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            lat_next      <= '0;
            lat_onehot    <= '0;
            lat_rw        <= 1'b0;
            wait_cnt      <= '0;
            mem_rdEn      <= 1'b0;
            mem_wrEn      <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_err   <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        lat_onehot <= gnt_onehot;
                        lat_next   <= gnt_next;
                        lat_rw     <= gnt_rw;
                        if (gnt_oor) begin
                            bus.rsp_valid <= gnt_onehot;
                            bus.rsp_err   <= gnt_onehot;
                            state         <= RESP;
                        end else begin
                            mem_addr <= gnt_addr;
                            mem_rdEn <= gnt_rw;
                            mem_wrEn <= !gnt_rw;
                            if (!gnt_rw)
                                mem_wdata <= gnt_wdata;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_rdEn <= 1'b0;
                    mem_wrEn <= 1'b0;
                    if (lat_rw) begin
                        wait_cnt <= 3'(RD_LAT - 1);
                        state    <= WAIT;
                    end else begin
                        bus.rsp_valid <= lat_onehot;
                        state         <= RESP;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        bus.rsp_rdata <= mem_rdata;
                        bus.rsp_valid <= lat_onehot;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    bus.rsp_valid <= '0;
                    bus.rsp_err   <= '0;
                    rr_ptr        <= lat_next;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
